// File: rtl/uart_decoder_pkg.sv
// Shared definitions for the UART 8N1 receive decoder.
//   state_t    : decoder FSM states
//   DATA_BITS  : data bits per frame
//   BIT_W      : width of the data-bit index
//   MIN_PERIOD : smallest usable bit period; smaller requests are raised to it
package uart_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam int DATA_BITS  = 8;
   localparam int BIT_W      = $clog2(DATA_BITS);
   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/uart_decoder_if.sv
// Signal bundle between a UART decoder and its user.
//   i_Period      : clocks per UART bit (0 and 1 behave as 2)
//   i_UART_RX     : serial line, idle high, asynchronous
//   o_Byte        : last correctly framed byte, held until the next one
//   o_Valid       : one-cycle strobe in the cycle o_Byte updates
//   o_Frame_Error : one-cycle strobe when a stop bit samples low
//   o_Busy        : high whenever the decoder is not idle
//   o_State       : current FSM state, for debug and checkers
// Handshake: o_Valid is a single-cycle strobe with no ready/back-pressure;
// the consumer must take o_Byte in the cycle o_Valid is high (o_Byte itself
// stays stable until the next strobe).
interface uart_decoder_if
   import uart_decoder_pkg::*;
#(
   parameter int PERIOD_W = 20
);
   logic [PERIOD_W-1:0] i_Period;
   logic                i_UART_RX;
   logic [7:0]          o_Byte;
   logic                o_Valid;
   logic                o_Frame_Error;
   logic                o_Busy;
   state_t              o_State;

   modport master (
      output i_Period, i_UART_RX,
      input  o_Byte, o_Valid, o_Frame_Error, o_Busy, o_State
   );

   modport slave (
      input  i_Period, i_UART_RX,
      output o_Byte, o_Valid, o_Frame_Error, o_Busy, o_State
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Input synchronizer and falling-edge detector for the UART RX line.
//   i_Clk, i_Reset : clock, asynchronous active-high reset
//   i_Rx           : raw asynchronous serial line
//   o_Rx_S         : line after SYNC_STAGES flops
//   o_Fell         : high for one cycle when o_Rx_S goes from 1 to 0
// All flops reset to 1 (idle line). A short priming register suppresses
// o_Fell until the pipeline holds real line samples, so a line that is
// already low when reset is released is not mistaken for a start bit.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Rx,
   output logic o_Rx_S,
   output logic o_Fell
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_d_q;
   logic [SYNC_STAGES:0]   prime_q;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         sync_q  <= '1;
         rx_d_q  <= 1'b1;
         prime_q <= '0;
      end else begin
         sync_q[0] <= i_Rx;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         rx_d_q  <= sync_q[SYNC_STAGES-1];
         prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign o_Rx_S = sync_q[SYNC_STAGES-1];
   assign o_Fell = prime_q[SYNC_STAGES] & rx_d_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_decoder.sv
// UART 8N1 receive decoder.
//   i_Clk, i_Reset : clock, asynchronous active-high reset
//   bus (slave)    : i_Period, i_UART_RX in; o_Byte, o_Valid,
//                    o_Frame_Error, o_Busy, o_State out
// The start bit is checked at its middle (floor(P/2) clocks after the
// falling edge); every later bit is sampled P clocks after the previous
// sample, i.e. also mid-bit. The period is latched at start detection so
// i_Period may change freely while a frame is in flight.
module uart_decoder
   import uart_decoder_pkg::*;
#(
   parameter int PERIOD_W    = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic           i_Clk,
   input  logic           i_Reset,
   uart_decoder_if.slave  bus
);

   logic rx_s;
   logic rx_fell;

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Rx    (bus.i_UART_RX),
      .o_Rx_S  (rx_s),
      .o_Fell  (rx_fell)
   );

   state_t                state_q, state_d;
   logic [PERIOD_W-1:0]   p_q;
   logic [PERIOD_W-1:0]   p_eff;
   logic [PERIOD_W-1:0]   cnt_q;
   logic [PERIOD_W-1:0]   half_m1;
   logic [PERIOD_W-1:0]   full_m1;
   logic [BIT_W-1:0]      bit_q;
   logic [DATA_BITS-1:0]  shreg_q;
   logic [7:0]            byte_q;
   logic                  valid_q;
   logic                  ferr_q;

   // Control strobes from the FSM to the datapath
   logic latch_p;
   logic cnt_clr;
   logic shift_en;
   logic byte_ld;
   logic frame_err;

   // Periods below MIN_PERIOD would give a zero half-period
   assign p_eff   = (bus.i_Period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                            : bus.i_Period;
   assign half_m1 = (p_q >> 1) - PERIOD_W'(1);
   assign full_m1 = p_q - PERIOD_W'(1);

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      latch_p   = 1'b0;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      byte_ld   = 1'b0;
      frame_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // rx_fell already implies rx_s was high in the previous cycle,
            // so a line stuck low after a frame error is not accepted.
            if (rx_fell) begin
               state_d = ST_START;
               latch_p = 1'b1;
               cnt_clr = 1'b1;
            end
         end
         ST_START: begin
            if (cnt_q == half_m1) begin
               cnt_clr = 1'b1;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == full_m1) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            // Leaving at mid-stop-bit leaves half a bit of margin to catch
            // a start bit that follows the stop bit directly.
            if (cnt_q == full_m1) begin
               cnt_clr = 1'b1;
               state_d = ST_IDLE;
               if (rx_s) begin
                  byte_ld = 1'b1;
               end else begin
                  frame_err = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         p_q     <= PERIOD_W'(MIN_PERIOD);
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         byte_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         valid_q <= byte_ld;
         ferr_q  <= frame_err;
         if (latch_p) begin
            p_q <= p_eff;
         end
         if (cnt_clr || (state_q == ST_IDLE)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + PERIOD_W'(1);
         end
         if (latch_p) begin
            bit_q <= '0;
         end else if (shift_en) begin
            bit_q <= bit_q + BIT_W'(1);
         end
         // LSB arrives first, so shift in from the top
         if (shift_en) begin
            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
         end
         if (byte_ld) begin
            byte_q <= shreg_q;
         end
      end
   end

   assign bus.o_Byte        = byte_q;
   assign bus.o_Valid       = valid_q;
   assign bus.o_Frame_Error = ferr_q;
   assign bus.o_Busy        = (state_q != ST_IDLE);
   assign bus.o_State       = state_q;

endmodule

// File: tb/tb_uart_decoder.sv
// Directed testbench for uart_decoder: sends 8N1 frames at several bit
// periods and checks received bytes, strobes, framing errors, reset
// behaviour and mid-frame period changes.
module tb_uart_decoder;
   import uart_decoder_pkg::*;

   localparam int PW = 20;

   logic i_Clk;
   logic i_Reset;

   uart_decoder_if #(.PERIOD_W(PW)) bus ();

   uart_decoder #(
      .PERIOD_W    (PW),
      .SYNC_STAGES (2)
   ) dut (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   int cyc = 0;
   always @(posedge i_Clk) cyc++;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int valid_cnt = 0;
   int ferr_cnt  = 0;
   int start_cyc = 0;
   int last_valid_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge i_Clk) begin
      if (bus.o_Valid === 1'b1) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("spurious_valid_queue_size", 32'(exp_q.size()), 32'd1);
         end else begin
            check("rx_byte", 32'(bus.o_Byte), 32'(exp_q.pop_front()));
         end
      end
      if (bus.o_Frame_Error === 1'b1) begin
         ferr_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_Clk);
         #1;
      end
   endtask

   // chg_bit >= 0 changes i_Period to chg_p in the middle of that data bit
   task automatic send_frame(input logic [7:0] data, input int p, input logic stop_bit,
                             input int chg_bit, input int chg_p);
      bus.i_UART_RX = 1'b0;
      start_cyc = cyc;
      tick(p);
      for (int i = 0; i < 8; i++) begin
         bus.i_UART_RX = data[i];
         if (i == chg_bit) begin
            tick(p / 2);
            bus.i_Period = PW'(chg_p);
            tick(p - p / 2);
         end else begin
            tick(p);
         end
      end
      bus.i_UART_RX = stop_bit;
      tick(p);
   endtask

   task automatic check_idle_outputs(input string tag, input logic [7:0] exp_byte);
      check({tag, "_byte"},  32'(bus.o_Byte), 32'(exp_byte));
      check({tag, "_valid"}, 32'(bus.o_Valid), 32'd0);
      check({tag, "_ferr"},  32'(bus.o_Frame_Error), 32'd0);
      check({tag, "_busy"},  32'(bus.o_Busy), 32'd0);
      check({tag, "_state"}, 32'(bus.o_State), 32'(ST_IDLE));
   endtask

   // ---------------- stimulus ----------------
   int v0;
   int f0;
   int lat;

   initial begin
      i_Reset       = 1'b1;
      bus.i_UART_RX = 1'b1;
      bus.i_Period  = PW'(16);
      tick(3);
      check_idle_outputs("reset", 8'h00);
      i_Reset = 1'b0;
      tick(5);

      // P=2: 0xAA, 4 idle clocks, 0x55
      v0 = valid_cnt; f0 = ferr_cnt;
      bus.i_Period = PW'(2);
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      send_frame(8'hAA, 2, 1'b1, -1, 0);
      tick(4);
      send_frame(8'h55, 2, 1'b1, -1, 0);
      tick(10);
      check("p2_valid_count", 32'(valid_cnt - v0), 32'd2);
      check("p2_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("p2_last_byte", 32'(bus.o_Byte), 32'h55);

      // i_Period=0 behaves as 2
      v0 = valid_cnt;
      bus.i_Period = PW'(0);
      exp_q.push_back(8'h96);
      send_frame(8'h96, 2, 1'b1, -1, 0);
      tick(10);
      check("p0_valid_count", 32'(valid_cnt - v0), 32'd1);
      check("p0_byte", 32'(bus.o_Byte), 32'h96);

      // P=868: 0x00 then 0xFF back-to-back
      v0 = valid_cnt; f0 = ferr_cnt;
      bus.i_Period = PW'(868);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 868, 1'b1, -1, 0);
      send_frame(8'hFF, 868, 1'b1, -1, 0);
      tick(868);
      check("p868_valid_count", 32'(valid_cnt - v0), 32'd2);
      check("p868_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("p868_last_byte", 32'(bus.o_Byte), 32'hFF);

      // P=16: 4-clock low glitch
      v0 = valid_cnt; f0 = ferr_cnt;
      bus.i_Period = PW'(16);
      bus.i_UART_RX = 1'b0;
      tick(4);
      bus.i_UART_RX = 1'b1;
      tick(3);
      check("glitch_busy_during", 32'(bus.o_Busy), 32'd1);
      tick(40);
      check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      check_idle_outputs("glitch_after", 8'hFF);

      // P=16: 0x3C with low stop bit, then 0x81
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, 16, 1'b0, -1, 0);
      check("ferr_pulse_count", 32'(ferr_cnt - f0), 32'd1);
      check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("ferr_byte_held", 32'(bus.o_Byte), 32'hFF);
      bus.i_UART_RX = 1'b1;
      tick(20);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 16, 1'b1, -1, 0);
      tick(16);
      check("after_ferr_valid_count", 32'(valid_cnt - v0), 32'd1);
      check("after_ferr_byte", 32'(bus.o_Byte), 32'h81);
      // start edge to strobe: SYNC_STAGES + 8 + 9*16 = 154, +/-1
      lat = last_valid_cyc - start_cyc;
      check("latency_p16_in_range", 32'(lat >= 153 && lat <= 155), 32'd1);

      // P=16: reset during data bit 4 (line low), then 0x5A
      v0 = valid_cnt; f0 = ferr_cnt;
      bus.i_UART_RX = 1'b0;
      start_cyc = cyc;
      tick(16 * 5 + 8);
      i_Reset = 1'b1;
      tick(3);
      check_idle_outputs("midreset", 8'h00);
      i_Reset = 1'b0;
      tick(56);
      bus.i_UART_RX = 1'b1;
      tick(60);
      check("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("midreset_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      check_idle_outputs("midreset_after", 8'h00);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 16, 1'b1, -1, 0);
      tick(16);
      check("midreset_next_valid", 32'(valid_cnt - v0), 32'd1);
      check("midreset_next_byte", 32'(bus.o_Byte), 32'h5A);

      // Period change 16 -> 4 during data bit 2
      v0 = valid_cnt; f0 = ferr_cnt;
      bus.i_Period = PW'(16);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 16, 1'b1, 2, 4);
      tick(16);
      check("pchg_first_byte", 32'(bus.o_Byte), 32'hC3);
      exp_q.push_back(8'h3E);
      send_frame(8'h3E, 4, 1'b1, -1, 0);
      tick(8);
      check("pchg_second_byte", 32'(bus.o_Byte), 32'h3E);
      check("pchg_valid_count", 32'(valid_cnt - v0), 32'd2);
      check("pchg_no_ferr", 32'(ferr_cnt - f0), 32'd0);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
